// File: rtl/ysyx_23060240_seq_ctrl.sv
// Multi-cycle sequencing controller for the NPC core: steps each instruction through
// fetch/decode/exec/mem/wb, owns the IFU/LSU handshakes, halt/error flags and perf counters.
module ysyx_23060240_seq_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ifu_req,
  input  logic             ifu_ack,
  input  logic [31:0]      ifu_rdata,
  output logic [31:0]      inst,
  input  logic             dec_w_en,
  input  logic [2:0]       dec_rd_ctrl,
  input  logic [1:0]       dec_wr_ctrl,
  input  logic             halt_in,
  output logic             lsu_req,
  output logic             lsu_we,
  input  logic             lsu_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic             retire,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int unsigned INST_W = 32;
  localparam int unsigned WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    instret_q, instret_d;

  logic                is_load;
  logic                is_store;
  logic [WAIT_W-1:0]   wait_inc;
  logic                timeout_hit;

  assign is_load     = |dec_rd_ctrl;
  assign is_store    = |dec_wr_ctrl;
  assign wait_inc    = wait_q + WAIT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (wait_inc == WAIT_W'(TIMEOUT));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      inst_q    <= '0;
      wait_q    <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      wait_q    <= wait_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    wait_d    = '0;
    cycle_d   = cycle_q;
    instret_d = instret_q;
    ifu_req   = 1'b0;
    lsu_req   = 1'b0;
    lsu_we    = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    err       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        ifu_req = 1'b1;
        cycle_d = cycle_q + CNT_W'(1);
        if (ifu_ack) begin
          inst_d  = ifu_rdata;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_DECODE: begin
        cycle_d = cycle_q + CNT_W'(1);
        state_d = halt_in ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        cycle_d = cycle_q + CNT_W'(1);
        if (is_load && is_store) begin
          state_d = S_ERR;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_we  = is_store;
        cycle_d = cycle_q + CNT_W'(1);
        if (lsu_ack) begin
          state_d = S_WB;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_WB: begin
        rf_we     = dec_w_en;
        pc_we     = 1'b1;
        retire    = 1'b1;
        cycle_d   = cycle_q + CNT_W'(1);
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  assign inst        = inst_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_ysyx_23060240_seq_ctrl.sv
// Scoreboard bench for ysyx_23060240_seq_ctrl: randomized instruction stream, expected
// retire/halt/error events queued by a transaction-level model and checked by a monitor.
module tb_ysyx_23060240_seq_ctrl;

  localparam int unsigned CW = 4;
  localparam int unsigned TO = 4;
  localparam int MASK   = (1 << CW) - 1;
  localparam int K_RET  = 0;
  localparam int K_HALT = 1;
  localparam int K_ERR  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ifu_req;
  logic          ifu_ack = 1'b0;
  logic [31:0]   ifu_rdata = '0;
  logic [31:0]   inst;
  logic          dec_w_en = 1'b0;
  logic [2:0]    dec_rd_ctrl = '0;
  logic [1:0]    dec_wr_ctrl = '0;
  logic          halt_in = 1'b0;
  logic          lsu_req;
  logic          lsu_we;
  logic          lsu_ack = 1'b0;
  logic          rf_we;
  logic          pc_we;
  logic          retire;
  logic          halted;
  logic          err;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] instret_cnt;

  always #5 clk = ~clk;

  ysyx_23060240_seq_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ifu_req     (ifu_req),
    .ifu_ack     (ifu_ack),
    .ifu_rdata   (ifu_rdata),
    .inst        (inst),
    .dec_w_en    (dec_w_en),
    .dec_rd_ctrl (dec_rd_ctrl),
    .dec_wr_ctrl (dec_wr_ctrl),
    .halt_in     (halt_in),
    .lsu_req     (lsu_req),
    .lsu_we      (lsu_we),
    .lsu_ack     (lsu_ack),
    .rf_we       (rf_we),
    .pc_we       (pc_we),
    .retire      (retire),
    .halted      (halted),
    .err         (err),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  typedef struct {
    int          kind;
    int          rf;
    int          we;
    int          memc;
    logic [31:0] word;
    int          cyc;
    int          ret;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_cyc    = 0;
  int   m_ret    = 0;
  int   mon_memc = 0;
  int   mon_we   = 0;
  bit   prev_h   = 1'b0;
  bit   prev_e   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected event per retire strobe or halt/err rising edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mon_memc = 0;
      mon_we   = 0;
      prev_h   = 1'b0;
      prev_e   = 1'b0;
    end else begin
      if (lsu_req) begin
        mon_memc++;
        mon_we = int'(lsu_we);
      end
      if (retire || pc_we || rf_we) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 32'(retire), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("retire_kind", 32'(K_RET), 32'(e.kind));
          chk("retire", 32'(retire), 32'd1);
          chk("pc_we", 32'(pc_we), 32'd1);
          chk("rf_we", 32'(rf_we), 32'(e.rf));
          chk("lsu_we", 32'(mon_we), 32'(e.we));
          chk("lsu_req_cycles", 32'(mon_memc), 32'(e.memc));
          chk("inst", inst, e.word);
          chk("cycle_cnt_wb", 32'(cycle_cnt), 32'(e.cyc));
          chk("instret_cnt_wb", 32'(instret_cnt), 32'(e.ret));
        end
        mon_memc = 0;
        mon_we   = 0;
      end
      if ((halted && !prev_h) || (err && !prev_e)) begin
        if (sb.size() == 0) begin
          chk("unexpected_halt_err", 32'({halted, err}), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("stop_kind", halted ? 32'(K_HALT) : 32'(K_ERR), 32'(e.kind));
          chk("cycle_cnt_stop", 32'(cycle_cnt), 32'(e.cyc));
          chk("instret_cnt_stop", 32'(instret_cnt), 32'(e.ret));
          chk("ifu_req_stop", 32'(ifu_req), 32'd0);
          chk("lsu_req_stop", 32'(lsu_req), 32'd0);
        end
      end
      prev_h = halted;
      prev_e = err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!ifu_req && n < 20) begin
      tick();
      n++;
    end
    if (!ifu_req) chk("ifu_req_wait", 32'(ifu_req), 32'd1);
  endtask

  task automatic reset_on();
    rst_n       = 1'b0;
    ifu_ack     = 1'b0;
    lsu_ack     = 1'b0;
    halt_in     = 1'b0;
    dec_w_en    = 1'b0;
    dec_rd_ctrl = '0;
    dec_wr_ctrl = '0;
    #1;
    chk("rst_ifu_req", 32'(ifu_req), 32'd0);
    chk("rst_lsu_req", 32'(lsu_req), 32'd0);
    chk("rst_strobes", 32'({rf_we, pc_we, retire, lsu_we}), 32'd0);
    chk("rst_flags", 32'({halted, err}), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("rst_instret_cnt", 32'(instret_cnt), 32'd0);
    chk("events_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    m_cyc = 0;
    m_ret = 0;
  endtask

  task automatic reset_off();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_no_req", 32'(ifu_req), 32'd0);
    tick();
    chk("first_ifu_req", 32'(ifu_req), 32'd1);
  endtask

  // Drive one instruction; the expected outcome is queued before it can be observed
  task automatic do_inst(input logic [31:0] word, input int fd, input bit halt,
                         input logic [2:0] rd, input logic [1:0] wr, input bit wen,
                         input int md, input bit abort);
    bit   mem = (rd != 0) || (wr != 0);
    bit   ill = (rd != 0) && (wr != 0);
    int   tot;
    exp_t e;
    wait_req();
    for (int i = 0; i < fd; i++) begin
      lsu_ack = 1'($urandom);
      tick();
    end
    lsu_ack     = 1'b0;
    ifu_ack     = 1'b1;
    ifu_rdata   = word;
    dec_w_en    = wen;
    dec_rd_ctrl = rd;
    dec_wr_ctrl = wr;
    halt_in     = halt;
    if (halt) begin
      e = '{K_HALT, 0, 0, 0, word, (m_cyc + fd + 2) & MASK, m_ret & MASK};
      sb.push_back(e);
      m_cyc += fd + 2;
    end else if (ill) begin
      e = '{K_ERR, 0, 0, 0, word, (m_cyc + fd + 3) & MASK, m_ret & MASK};
      sb.push_back(e);
      m_cyc += fd + 3;
    end else if (!abort) begin
      tot = fd + 4 + (mem ? md + 1 : 0);
      e = '{K_RET, int'(wen), int'(wr != 0), mem ? md + 1 : 0, word,
            (m_cyc + tot - 1) & MASK, m_ret & MASK};
      sb.push_back(e);
      m_cyc += tot;
      m_ret++;
    end
    tick();
    ifu_ack = 1'b0;
    if (halt) begin
      tick();
      return;
    end
    tick();
    halt_in = 1'($urandom);
    if (ill) begin
      tick();
      return;
    end
    if (mem) begin
      tick();
      if (abort) begin
        rst_n = 1'b0;
        #1;
        chk("abort_lsu_req", 32'(lsu_req), 32'd0);
        chk("abort_strobes", 32'({rf_we, pc_we, retire}), 32'd0);
        return;
      end
      for (int i = 0; i < md; i++) begin
        ifu_ack = 1'($urandom);
        tick();
      end
      ifu_ack = 1'b0;
      lsu_ack = 1'b1;
      tick();
      lsu_ack = 1'b0;
    end
    halt_in = 1'b0;
  endtask

  task automatic rand_inst();
    int          k  = int'($urandom_range(0, 2));
    logic [2:0]  rd = (k == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
    logic [1:0]  wr = (k == 2) ? 2'($urandom_range(1, 3)) : 2'd0;
    do_inst($urandom, int'($urandom_range(0, TO - 1)), 1'b0, rd, wr, 1'($urandom),
            int'($urandom_range(0, TO - 1)), 1'b0);
  endtask

  initial begin
    #3;
    reset_on();
    #20;
    reset_off();

    repeat (3) do_inst(32'h0010_0093, 0, 1'b0, 3'd0, 2'd0, 1'b1, 0, 1'b0);
    wait_req();
    chk("cycle_after_3_addi", 32'(cycle_cnt), 32'd12);
    chk("instret_after_3_addi", 32'(instret_cnt), 32'd3);

    do_inst(32'h0000_2083, 0, 1'b0, 3'b101, 2'd0, 1'b1, 2, 1'b0);
    do_inst(32'h0010_2023, 0, 1'b0, 3'd0, 2'b11, 1'b0, 1, 1'b0);
    repeat (30) rand_inst();

    do_inst(32'h0010_0073, 1, 1'b1, 3'd0, 2'd0, 1'b0, 0, 1'b0);
    repeat (3) tick();
    chk("halted_sticky", 32'(halted), 32'd1);
    chk("halt_no_req", 32'({ifu_req, lsu_req}), 32'd0);
    chk("halt_cycle_frozen", 32'(cycle_cnt), 32'(m_cyc & MASK));
    chk("halt_instret_frozen", 32'(instret_cnt), 32'(m_ret & MASK));
    reset_on();
    tick();
    reset_off();

    repeat (3) rand_inst();
    do_inst(32'h1234_5678, 0, 1'b0, 3'b001, 2'b01, 1'b1, 0, 1'b0);
    tick();
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_no_req", 32'({ifu_req, lsu_req}), 32'd0);
    reset_on();
    reset_off();

    repeat (3) rand_inst();
    wait_req();
    sb.push_back('{K_ERR, 0, 0, 0, 32'd0, (m_cyc + int'(TO)) & MASK, m_ret & MASK});
    for (int i = 0; i < int'(TO); i++) begin
      lsu_ack = 1'($urandom);
      tick();
    end
    lsu_ack = 1'b0;
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_no_req", 32'(ifu_req), 32'd0);
    tick();
    reset_on();
    reset_off();

    repeat (4) rand_inst();
    do_inst(32'h0040_2103, 1, 1'b0, 3'b010, 2'd0, 1'b1, 1, 1'b1);
    reset_on();
    reset_off();

    repeat (4) rand_inst();
    wait_req();
    chk("final_events_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/ysyx_23060240_seq_ctrl.md
# ysyx_23060240_seq_ctrl

Multi-cycle sequencing controller for the NPC core. It drives each instruction through fetch, decode, execute, optional memory access and write-back. It holds the fetched instruction stable for the decoder and gates the register-file and PC write enables. It also owns the instruction-fetch and load/store handshakes, halt/error detection and the cycle/instret performance counters.

## Interface
Parameters:
- CNT_W, 32: width of cycle and instret counters.
- TIMEOUT, 255: maximum wait cycles for an ack in FETCH or MEM before entering ERR. 0 disables the timeout.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- ifu_req  out  1  fetch request; high for the whole of FETCH.
- ifu_ack  in  1  fetch data valid this cycle.
- ifu_rdata  in  32  fetched instruction word.
- inst  out  32  registered instruction, fed to the decoder.
- dec_w_en  in  1  decoder register-write enable.
- dec_rd_ctrl  in  3  decoder load mode; nonzero means load.
- dec_wr_ctrl  in  2  decoder store mode; nonzero means store.
- halt_in  in  1  decoder trap/ebreak indication.
- lsu_req  out  1  data memory request; high for the whole of MEM.
- lsu_we  out  1  1 = store, 0 = load; valid while lsu_req is high.
- lsu_ack  in  1  data access complete this cycle.
- rf_we  out  1  register-file write strobe.
- pc_we  out  1  PC update strobe.
- retire  out  1  instruction-retired pulse.
- halted  out  1  sticky halt flag.
- err  out  1  sticky error flag (timeout or illegal memory control).
- cycle_cnt  out  CNT_W  active cycle count.
- instret_cnt  out  CNT_W  retired instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- Reset (rst_n low): state = IDLE, inst = 0, both counters 0, wait counter 0, halted = 0, err = 0. All strobes and requests are 0.
- IDLE: outputs inactive; goes to FETCH unconditionally on the next edge.
- FETCH: ifu_req = 1.
  - On ifu_ack: inst <= ifu_rdata, go to DECODE.
  - Otherwise the wait counter increments. If it reaches TIMEOUT (TIMEOUT ≠ 0), go to ERR.
- DECODE: one cycle for the decoder outputs to settle from inst.
  - halt_in = 1: go to HALT.
  - Otherwise: go to EXEC.
- EXEC: one cycle.
  - dec_rd_ctrl ≠ 0 and dec_wr_ctrl ≠ 0 together: go to ERR.
  - Either one nonzero: go to MEM.
  - Otherwise: go to WB.
- MEM: lsu_req = 1; lsu_we = (dec_wr_ctrl ≠ 0).
  - On lsu_ack: go to WB.
  - Timeout behaves as in FETCH.
- WB: one cycle; rf_we = dec_w_en, pc_we = 1, retire = 1; then back to FETCH.
- HALT and ERR are absorbing until reset. halted = 1 in HALT; err = 1 in ERR; no requests are issued.
- Wait counter clears on every state change. It is at least clog2(TIMEOUT+1) bits wide.
- cycle_cnt increments in every state except IDLE, HALT and ERR.
- instret_cnt increments in WB.
- Both counters wrap modulo 2^CNT_W without flagging.
- ifu_ack outside FETCH and lsu_ack outside MEM are ignored.
- halt_in is sampled in DECODE only.
- inst changes only on an accepted fetch.

## Timing
- All outputs are Moore (decoded from registered state) except rf_we and lsu_we, which also depend on the decoder inputs combinationally from inst.
- Minimum instruction latency, counted from FETCH entry to the next FETCH entry:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each extra wait cycle in FETCH or MEM adds 1.
- First ifu_req rises one cycle after rst_n deasserts.
- Strobes rf_we, pc_we and retire are exactly 1 cycle wide per instruction.
- Counter values update on the same edge that leaves the counted state.
- Asynchronous reset mid-MEM or mid-FETCH drops all requests immediately. No write strobe is produced for the aborted instruction.
- Timeout: entry to ERR happens on the edge where the wait count equals TIMEOUT, i.e. after TIMEOUT non-ack cycles.

## Test plan
- Reset, then ifu_ack held high with addi (0x00100093), dec_w_en = 1 → ifu_req high from cycle 1; rf_we/pc_we/retire pulse every 4 cycles; instret_cnt = 3 after 12 active cycles.
- Load: dec_rd_ctrl = 3'b101, lsu_ack delayed 2 cycles → lsu_req high 3 cycles, lsu_we = 0, WB follows, 7-cycle instruction.
- Store: dec_wr_ctrl = 2'b11, dec_w_en = 0 → lsu_we = 1 in MEM, rf_we = 0 and pc_we = 1 in WB.
- halt_in = 1 in DECODE → halted = 1 from next cycle; no further ifu_req; counters frozen; rst_n pulse → IDLE and counters 0.
- TIMEOUT = 4, ifu_ack never asserted → err = 1 after 4 FETCH cycles; ifu_req low thereafter.
- CNT_W = 4, 16 instructions → instret_cnt wraps to 0; rst_n asserted mid-MEM → lsu_req drops the same cycle with no rf_we.
